// File: rtl/gpio_ctrl.sv
// ============================================================================
// Module  : gpio_ctrl
// Brief   : Register-mapped GPIO bank with per-pin IOBUF, 2-flop synchroniser,
//           edge capture into W1C status and a level irq.
//           Define GPIO_DEBOUNCE_EN to add the per-bit input debouncer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_ctrl #(
    parameter int GPIO_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [2:0]            wr_addr,
    input  logic [GPIO_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [2:0]            rd_addr,
    output logic [GPIO_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  irq,
    inout  wire  [GPIO_WIDTH-1:0] gpio_io
);

    localparam logic [2:0] ADDR_OUT     = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IN      = 3'd2;
    localparam logic [2:0] ADDR_IRQ_EN  = 3'd3;
    localparam logic [2:0] ADDR_RISE_EN = 3'd4;
    localparam logic [2:0] ADDR_FALL_EN = 3'd5;
    localparam logic [2:0] ADDR_STAT    = 3'd6;
    localparam logic [1:0] ARM_DONE     = 2'd3;

    if (GPIO_WIDTH < 1 || GPIO_WIDTH > 32 || DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_param_check
        $error("gpio_ctrl: GPIO_WIDTH or DEBOUNCE_CYCLES out of legal range");
    end

    logic [GPIO_WIDTH-1:0] out_q, out_d, dir_q, dir_d;
    logic [GPIO_WIDTH-1:0] irq_en_q, irq_en_d, rise_en_q, rise_en_d, fall_en_q, fall_en_d;
    logic [GPIO_WIDTH-1:0] stat_q, stat_d;
    logic [GPIO_WIDTH-1:0] sync1_q, sync2_q, prev_q;
    logic [GPIO_WIDTH-1:0] pin_in, in_w, cap_w, rd_mux;
    logic [GPIO_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q, irq_q;
    logic [1:0]            arm_q;

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_iobuf
        assign gpio_io[i] = dir_q[i] ? out_q[i] : 1'bz;
        assign pin_in[i]  = gpio_io[i];
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [GPIO_WIDTH-1:0] in_q;
    logic [7:0]            db_cnt_q [GPIO_WIDTH];

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_debounce
        always_ff @(posedge clk) begin
            if (rst) begin
                in_q[i]     <= 1'b0;
                db_cnt_q[i] <= 8'd0;
            end else if (sync2_q[i] == in_q[i]) begin
                db_cnt_q[i] <= 8'd0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                in_q[i]     <= sync2_q[i];
                db_cnt_q[i] <= 8'd0;
            end else begin
                db_cnt_q[i] <= db_cnt_q[i] + 8'd1;
            end
        end
    end

    assign in_w = in_q;
`else
    assign in_w = sync2_q;
`endif

    // Capture stays off until the synchroniser has filled with real pin values,
    // so pins already high when reset releases do not look like rising edges.
    assign cap_w = (arm_q == ARM_DONE)
                 ? ((in_w & ~prev_q & rise_en_q) | (~in_w & prev_q & fall_en_q))
                 : '0;

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        irq_en_d  = irq_en_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        stat_d    = stat_q | cap_w;
        if (wr_en) begin
            case (wr_addr)
                ADDR_OUT:     out_d     = wr_data;
                ADDR_DIR:     dir_d     = wr_data;
                ADDR_IRQ_EN:  irq_en_d  = wr_data;
                ADDR_RISE_EN: rise_en_d = wr_data;
                ADDR_FALL_EN: fall_en_d = wr_data;
                ADDR_STAT:    stat_d    = (stat_q & ~wr_data) | cap_w;
                default:      ;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_addr)
            ADDR_OUT:     rd_mux = out_q;
            ADDR_DIR:     rd_mux = dir_q;
            ADDR_IN:      rd_mux = in_w;
            ADDR_IRQ_EN:  rd_mux = irq_en_q;
            ADDR_RISE_EN: rd_mux = rise_en_q;
            ADDR_FALL_EN: rd_mux = fall_en_q;
            ADDR_STAT:    rd_mux = stat_q;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q      <= '0;
            dir_q      <= '0;
            irq_en_q   <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            stat_q     <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            arm_q      <= 2'd0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            dir_q      <= dir_d;
            irq_en_q   <= irq_en_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            stat_q     <= stat_d;
            sync1_q    <= pin_in;
            sync2_q    <= sync1_q;
            prev_q     <= in_w;
            if (arm_q != ARM_DONE) begin
                arm_q <= arm_q + 2'd1;
            end
            if (rd_en) begin
                rd_data_q <= rd_mux;
            end
            rd_valid_q <= rd_en;
            irq_q      <= |(stat_q & irq_en_q);
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign irq      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_ctrl.sv
// ============================================================================
// Module  : tb_gpio_ctrl
// Brief   : Directed self-checking bench for gpio_ctrl with a read scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_en;
    logic [2:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic         rd_en;
    logic [2:0]   rd_addr;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         irq;
    wire  [W-1:0] gpio_io;

    logic [W-1:0] tb_oe;
    logic [W-1:0] tb_val;

    logic [W-1:0] sb [$];
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < W; i++) begin : g_pin_drv
        assign gpio_io[i] = tb_oe[i] ? tb_val[i] : 1'bz;
    end

    gpio_ctrl #(.GPIO_WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .irq      (irq),
        .gpio_io  (gpio_io)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Every task starts and ends just after a falling edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [W-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic reg_read(input string tag, input logic [2:0] a, input logic [W-1:0] exp);
        logic [W-1:0] e;
        rd_en = 1'b1; rd_addr = a;
        sb.push_back(exp);
        @(negedge clk);
        e = sb.pop_front();
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check(tag, {16'd0, rd_data}, {16'd0, e});
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = '0;
        rd_en = 1'b0; rd_addr = 3'd0;
        tb_oe = '1; tb_val = '0;
        tick(3);
        rst = 1'b0;
        tick(3);

        // 1: reset state, all addresses read zero, valid is a single pulse
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_rdata", {16'd0, rd_data}, 32'd0);
        for (int a = 0; a < 8; a++) reg_read("rst_read", 3'(a), 16'h0000);
        tick(1);
        check("valid_drop", {31'd0, rd_valid}, 32'd0);

        // 2: low byte output, upper byte driven by the bench (proves high-Z)
        tb_oe = 16'hFF00; tb_val = 16'h3C00;
        reg_write(3'd1, 16'h00FF);
        reg_write(3'd0, 16'hA5A5);
        check("pin_low_byte", {24'd0, gpio_io[7:0]}, 32'hA5);
        reg_read("in_lat0", 3'd2, 16'h3C00);
        reg_read("in_lat1", 3'd2, 16'h3C00);
        reg_read("in_lat2", 3'd2, 16'h3CA5);
        tick(1);
        check("rdata_hold", {16'd0, rd_data}, 32'h3CA5);
        check("hold_valid", {31'd0, rd_valid}, 32'd0);
        reg_read("out_rb", 3'd0, 16'hA5A5);
        reg_read("dir_rb", 3'd1, 16'h00FF);
        reg_write(3'd2, 16'hFFFF);
        reg_write(3'd7, 16'hFFFF);
        reg_read("in_ro", 3'd2, 16'h3CA5);
        reg_read("rsvd_ro", 3'd7, 16'h0000);

        // 3: rising edge capture timing, irq lag, W1C
        reg_write(3'd1, 16'h0000);
        tb_oe = '1; tb_val = 16'h0000;
        reg_write(3'd4, 16'h0001);
        reg_write(3'd3, 16'h0001);
        tick(3);
        tb_val = 16'h0001;
        reg_read("stat_k0", 3'd6, 16'h0000);
        reg_read("stat_k1", 3'd6, 16'h0000);
        reg_read("stat_k2", 3'd6, 16'h0000);
        check("irq_k2", {31'd0, irq}, 32'd0);
        reg_read("stat_k3", 3'd6, 16'h0001);
        check("irq_k3", {31'd0, irq}, 32'd1);
        reg_write(3'd6, 16'h0001);
        check("irq_lag", {31'd0, irq}, 32'd1);
        reg_read("stat_w1c", 3'd6, 16'h0000);
        check("irq_drop", {31'd0, irq}, 32'd0);

        // 4: falls ignored, capture while disabled, enable on set bit, set beats clear
        tb_val = 16'h0000;
        tick(4);
        reg_read("no_fall", 3'd6, 16'h0000);
        reg_write(3'd3, 16'h0000);
        tb_val = 16'h0001;
        tick(4);
        reg_read("stat_dis", 3'd6, 16'h0001);
        check("irq_dis", {31'd0, irq}, 32'd0);
        reg_write(3'd3, 16'h0001);
        check("irq_en_lag", {31'd0, irq}, 32'd0);
        tick(1);
        check("irq_en_set", {31'd0, irq}, 32'd1);
        tb_val = 16'h0000;
        tick(4);
        reg_read("fall_keep", 3'd6, 16'h0001);
        tb_val = 16'h0001;
        tick(2);
        reg_write(3'd6, 16'h0001);
        reg_read("set_wins", 3'd6, 16'h0001);

        // 5: reset discards in-flight read; pin held high through reset
        tb_val = 16'h0008;
        rd_en = 1'b1; rd_addr = 3'd6; rst = 1'b1;
        tick(1);
        rd_en = 1'b0;
        check("rst_mid_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_mid_rdata", {16'd0, rd_data}, 32'd0);
        check("rst_mid_irq", {31'd0, irq}, 32'd0);
        tick(2);
        rst = 1'b0;
        reg_write(3'd4, 16'hFFFF);
        reg_read("hold_in_c1", 3'd2, 16'h0000);
        reg_read("hold_in_c2", 3'd2, 16'h0008);
        tick(4);
        reg_read("hold_stat", 3'd6, 16'h0000);
        check("hold_irq", {31'd0, irq}, 32'd0);

`ifdef GPIO_DEBOUNCE_EN
        // 6: short glitch filtered, stable change lands after DEBOUNCE_CYCLES
        tick(8);
        tb_val = 16'h000A;
        tick(3);
        tb_val = 16'h0008;
        tick(8);
        reg_read("glitch_in", 3'd2, 16'h0008);
        reg_read("glitch_stat", 3'd6, 16'h0000);
        tb_val = 16'h000A;
        for (int i = 0; i < 7; i++) reg_read("db_in", 3'd2, (i >= 6) ? 16'h000A : 16'h0008);
`endif

        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
